// File: rtl/seq_gen_pkg.sv
// Shared types and constants for the serial pattern generator and its detector.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Target sequence shared with the detector so both ends agree.
  localparam logic [3:0] SEQ_DEFAULT_PAT = 4'b1011;

endpackage

// File: rtl/seq_shift_reg.sv
// Parallel-load, shift-left register; load has priority over shift.
module seq_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] sr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_q <= '0;
    end else if (load) begin
      sr_q <= din;
    end else if (shift) begin
      sr_q <= {sr_q[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = sr_q[WIDTH-1];

endmodule

// File: rtl/seq_generator.sv
// Serial bit-pattern transmitter: sends a latched pattern MSB-first, reps+1 times,
// with GAP idle cycles between frames, then pulses done.
//
//   state  | meaning
//   S_IDLE | waiting for start; outputs quiet
//   S_SEND | shifting out one pattern bit per cycle (dvalid=1)
//   S_GAP  | idle gap between frames, counted down from GAP-1
//   S_DONE | single-cycle done pulse, returns to S_IDLE
module seq_generator
  import seq_gen_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter int               GAP         = 2,
  parameter logic [WIDTH-1:0] DEFAULT_PAT = WIDTH'(SEQ_DEFAULT_PAT)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic             use_default,
  input  logic [WIDTH-1:0] pattern,
  input  logic [3:0]       reps,
  output logic             dout,
  output logic             dvalid,
  output logic             busy,
  output logic             done
);

  localparam int BW = $clog2(WIDTH);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  state_t state_q, state_d;

  logic [WIDTH-1:0] pat_q;
  logic [BW-1:0]    bit_cnt_q;
  logic [GW-1:0]    gap_cnt_q;
  logic [3:0]       frame_cnt_q;

  logic             accept;
  logic             last_bit;
  logic             sr_load;
  logic             sr_shift;
  logic             sr_msb;
  logic [WIDTH-1:0] sr_din;

  assign last_bit = (bit_cnt_q == BIT_LAST);
  assign accept   = (state_q == S_IDLE) && start && !abort;

  // Fresh pattern at start; otherwise reload the latched copy between frames.
  assign sr_din = (state_q == S_IDLE) ? (use_default ? DEFAULT_PAT : pattern) : pat_q;

  always_comb begin
    state_d  = state_q;
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_SEND;
          sr_load = 1'b1;
        end
      end
      S_SEND: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (last_bit) begin
          if (frame_cnt_q == 4'd0) begin
            state_d = S_DONE;
          end else begin
            sr_load = 1'b1;
            state_d = (GAP == 0) ? S_SEND : S_GAP;
          end
        end else begin
          sr_shift = 1'b1;
        end
      end
      S_GAP: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (gap_cnt_q == '0) begin
          state_d = S_SEND;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pat_q       <= '0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      frame_cnt_q <= '0;
    end else if (accept) begin
      pat_q       <= sr_din;
      frame_cnt_q <= reps;
      bit_cnt_q   <= '0;
    end else if (!abort) begin
      if (state_q == S_SEND) begin
        if (last_bit) begin
          bit_cnt_q <= '0;
          if (frame_cnt_q != 4'd0) begin
            frame_cnt_q <= frame_cnt_q - 4'd1;
            gap_cnt_q   <= GAP_LAST;
          end
        end else begin
          bit_cnt_q <= bit_cnt_q + 1'b1;
        end
      end else if (state_q == S_GAP && gap_cnt_q != '0) begin
        gap_cnt_q <= gap_cnt_q - 1'b1;
      end
    end
  end

  seq_shift_reg #(
    .WIDTH(WIDTH)
  ) u_shift (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (sr_load),
    .shift  (sr_shift),
    .din    (sr_din),
    .msb    (sr_msb)
  );

  assign dout   = (state_q == S_SEND) && sr_msb;
  assign dvalid = (state_q == S_SEND);
  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);

endmodule

// File: tb/tb_seq_generator.sv
// Bench for seq_generator: two instances (GAP=2 and GAP=0) checked every cycle
// against a frame-list model, plus literal stream/duration expectations.
module tb_seq_generator;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       use_default = 1'b0;
  logic [3:0] pattern = 4'b0000;
  logic [3:0] reps = 4'd0;

  logic dout2, dvalid2, busy2, done2;
  logic dout0, dvalid0, busy0, done0;

  always #5 clk = ~clk;

  seq_generator #(.WIDTH(4), .GAP(2), .DEFAULT_PAT(4'b1011)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .use_default(use_default), .pattern(pattern), .reps(reps),
    .dout(dout2), .dvalid(dvalid2), .busy(busy2), .done(done2)
  );

  seq_generator #(.WIDTH(4), .GAP(0), .DEFAULT_PAT(4'b1011)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .use_default(use_default), .pattern(pattern), .reps(reps),
    .dout(dout0), .dvalid(dvalid0), .busy(busy0), .done(done0)
  );

  // Per-cycle expectation tuple: {dout, dvalid, busy, done}.
  typedef logic [3:0] q_t[$];
  q_t         qs[2];
  logic [3:0] ex[2];

  function automatic q_t build(input logic [3:0] p, input logic [3:0] r, input int gap);
    q_t q;
    q = {};
    for (int f = 0; f <= int'(r); f++) begin
      for (int b = 3; b >= 0; b--) q.push_back({p[b], 3'b110});
      if (f < int'(r)) for (int g = 0; g < gap; g++) q.push_back(4'b0010);
    end
    q.push_back(4'b0011);
    return q;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 2; k++) begin
        qs[k].delete();
        ex[k] = 4'b0000;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (ex[k][1]) begin
          if (abort) begin
            qs[k].delete();
            ex[k] = 4'b0000;
          end else if (qs[k].size() > 0) begin
            ex[k] = qs[k].pop_front();
          end else begin
            ex[k] = 4'b0000;
          end
        end else if (start && !abort) begin
          qs[k] = build(use_default ? 4'b1011 : pattern, reps, (k == 0) ? 2 : 0);
          ex[k] = qs[k].pop_front();
        end else begin
          ex[k] = 4'b0000;
        end
      end
    end
  end

  // Compare process: model check every cycle, plus literal checks posted by the stimulus.
  int          n_cmp = 0;
  int          n_err = 0;
  int          lit_req = 0;
  int          lit_done = 0;
  string       lit_nm;
  logic [31:0] lit_act;
  logic [31:0] lit_exp;

  always @(negedge clk) begin
    n_cmp++;
    if ({dout2, dvalid2, busy2, done2} !== ex[0]) begin
      n_err++;
      $display("FAIL model_gap2 t=%0t got dout/dvalid/busy/done=%b want %b", $time,
               {dout2, dvalid2, busy2, done2}, ex[0]);
    end
    n_cmp++;
    if ({dout0, dvalid0, busy0, done0} !== ex[1]) begin
      n_err++;
      $display("FAIL model_gap0 t=%0t got dout/dvalid/busy/done=%b want %b", $time,
               {dout0, dvalid0, busy0, done0}, ex[1]);
    end
    if (lit_req != lit_done) begin
      n_cmp++;
      if (lit_act !== lit_exp) begin
        n_err++;
        $display("FAIL %s got 0x%0h want 0x%0h", lit_nm, lit_act, lit_exp);
      end
      lit_done = lit_req;
    end
  end

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    lit_nm  = nm;
    lit_act = act;
    lit_exp = exp_v;
    lit_req++;
    @(negedge clk);
    #1;
  endtask

  // Measurements taken by the stimulus over one transaction.
  int          nb2, nb0, nd2, nd0, nv2, nv0, run0, maxrun0;
  logic [31:0] s2, s0;

  task automatic measure(input logic [3:0] pat, input logic [3:0] rp, input logic ud,
                         input bit chg, input int abort_i, input int start_i);
    bit finished;
    nb2 = 0; nb0 = 0; nd2 = 0; nd0 = 0; nv2 = 0; nv0 = 0; run0 = 0; maxrun0 = 0;
    s2 = '0; s0 = '0;
    finished = 1'b0;
    @(negedge clk);
    pattern = pat; reps = rp; use_default = ud; start = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      #1;
      if (i == 0) start = 1'b0;
      if (i == 0 && chg) begin
        pattern = ~pat;
        reps = rp + 4'd4;
        use_default = ~ud;
      end
      if (i == start_i) start = 1'b1;
      if (i == start_i + 1) start = 1'b0;
      if (i == abort_i) abort = 1'b1;
      if (i == abort_i + 1) abort = 1'b0;
      if (busy2) nb2++;
      if (busy0) nb0++;
      if (done2) nd2++;
      if (done0) nd0++;
      if (dvalid2) begin s2 = {s2[30:0], dout2}; nv2++; end
      if (dvalid0) begin s0 = {s0[30:0], dout0}; nv0++; run0++; end
      else run0 = 0;
      if (run0 > maxrun0) maxrun0 = run0;
      if (!busy2 && !busy0) begin
        finished = 1'b1;
        break;
      end
    end
    start = 1'b0;
    abort = 1'b0;
    lit("transaction_timeout", {31'd0, ~finished}, 32'd0);
  endtask

  initial begin
    #22 reset_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    lit("reset_outputs", {28'd0, dout2, dvalid2, busy2, done2}, 32'd0);

    // Single default frame.
    measure(4'b0000, 4'd0, 1'b1, 1'b0, -9, -9);
    lit("dflt_stream", s2, 32'hB);
    lit("dflt_bits", nv2, 32'd4);
    lit("dflt_busy", nb2, 32'd5);
    lit("dflt_done", nd2, 32'd1);
    lit("dflt_busy_gap0", nb0, 32'd5);

    // Three frames with gap.
    measure(4'b0110, 4'd2, 1'b0, 1'b0, -9, -9);
    lit("rep_stream", s2, 32'h666);
    lit("rep_bits", nv2, 32'd12);
    lit("rep_busy", nb2, 32'd17);
    lit("rep_busy_gap0", nb0, 32'd13);

    // Back-to-back frames on the GAP=0 instance.
    measure(4'b1100, 4'd1, 1'b0, 1'b0, -9, -9);
    lit("b2b_stream", s0, 32'hCC);
    lit("b2b_run", maxrun0, 32'd8);
    lit("b2b_busy", nb0, 32'd9);
    lit("b2b_done", nd0, 32'd1);

    // Inputs change right after the start edge.
    measure(4'b1001, 4'd1, 1'b0, 1'b1, -9, -9);
    lit("latch_stream", s2, 32'h99);
    lit("latch_busy", nb2, 32'd11);

    // Abort in the second gap; a start during SEND is ignored.
    measure(4'b1010, 4'd3, 1'b0, 1'b0, 10, 1);
    lit("abort_busy", nb2, 32'd11);
    lit("abort_bits", nv2, 32'd8);
    lit("abort_no_done", nd2 + nd0, 32'd0);

    // start and abort together in IDLE.
    @(negedge clk);
    pattern = 4'b1111; reps = 4'd0; use_default = 1'b0; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    nb2 = 0;
    repeat (4) begin @(negedge clk); #1; if (busy2 || busy0) nb2++; end
    lit("start_abort_idle", nb2, 32'd0);

    // Reset during the third bit.
    @(negedge clk);
    use_default = 1'b1; reps = 4'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    lit("reset_midframe", {28'd0, dout2, dvalid2, busy2, done2, dout0, dvalid0, busy0, done0}, 32'd0);
    #2 reset_n = 1'b1;
    nb2 = 0;
    repeat (6) begin @(negedge clk); #1; if (busy2 || busy0 || dvalid2 || dvalid0) nb2++; end
    lit("post_reset_quiet", nb2, 32'd0);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
